addsub_4bit_reg: RTL and testbench

//   4-bit two's-complement adder/subtractor with registered results.

---
 rtl/addsub_4bit_reg_if.sv | 31 +++
 rtl/addsub_4bit_reg.sv | 46 ++++
 tb/tb_addsub_4bit_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/addsub_4bit_reg_if.sv
// Operand/result bundle for the 4-bit registered adder/subtractor.
// There is no handshake: the producer presents A, B and sub before a rising
// clk edge, and the registered sum/ovfl/cout appear one edge later.
interface addsub_4bit_reg_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       sub;
  logic [3:0] sum;
  logic       ovfl;
  logic       cout;

  // Producer side: drives operands, observes registered results.
  modport master (
    output A,
    output B,
    output sub,
    input  sum,
    input  ovfl,
    input  cout
  );

  // Arithmetic block side: samples operands, drives registered results.
  modport slave (
    input  A,
    input  B,
    input  sub,
    output sum,
    output ovfl,
    output cout
  );
endinterface

// File: rtl/addsub_4bit_reg.sv
// 4-bit two's-complement adder/subtractor built from a ripple-carry chain of
// full adders. Subtraction is A + ~B + 1: B is inverted bitwise by sub and sub
// also feeds the carry-in. The sum and both flags are registered, giving one
// clock of latency and one result per cycle.
module addsub_4bit_reg (
  input  logic                  clk,
  input  logic                  rst_n,
  addsub_4bit_reg_if.slave      bus
);

  logic [3:0] bx;
  logic [4:0] c;
  logic [3:0] s;
  logic       ovfl_c;
  logic       cout_c;

  // Ripple-carry datapath: conditional B inversion, full-adder chain, flags.
  always_comb begin
    bx     = bus.B ^ {4{bus.sub}};
    c      = 5'b0;
    s      = 4'b0;
    c[0]   = bus.sub;
    for (int i = 0; i < 4; i++) begin
      s[i]   = bus.A[i] ^ bx[i] ^ c[i];
      c[i+1] = (bus.A[i] & bx[i]) | (c[i] & (bus.A[i] ^ bx[i]));
    end
    // Signed overflow: the carries into and out of the sign bit disagree.
    ovfl_c = c[4] ^ c[3];
    // For subtraction a set carry means no borrow (A >= B unsigned).
    cout_c = c[4];
  end

  // Result register; asynchronous reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum  <= 4'b0000;
      bus.ovfl <= 1'b0;
      bus.cout <= 1'b0;
    end else begin
      bus.sum  <= s;
      bus.ovfl <= ovfl_c;
      bus.cout <= cout_c;
    end
  end

endmodule

// File: tb/tb_addsub_4bit_reg.sv
// Bench for addsub_4bit_reg: directed corners, asynchronous reset, a latency
// stream, random vectors and an exhaustive sweep against a signed-integer model.
module tb_addsub_4bit_reg;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [5:0] exp_q[$];

  addsub_4bit_reg_if bus ();

  addsub_4bit_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: plain signed arithmetic on integers, packed as {sum,ovfl,cout}.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    int av;
    int bv;
    int r;
    logic [3:0] sm;
    logic ov;
    logic co;
    av = a[3] ? int'(a) - 16 : int'(a);
    bv = b[3] ? int'(b) - 16 : int'(b);
    r  = s ? av - bv : av + bv;
    ov = (r < -8) || (r > 7);
    sm = 4'(r & 15);
    if (s) co = (int'(a) >= int'(b));
    else   co = ((int'(a) + int'(b)) > 15);
    return {sm, ov, co};
  endfunction

  // Single checking task: counts every comparison and reports mismatches.
  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got sum=%b ovfl=%b cout=%b, want sum=%b ovfl=%b cout=%b",
               tag, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.sum, bus.ovfl, bus.cout};
  endfunction

  // Driver: present operands on the falling edge, queue the expected result.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [5:0] e);
    @(negedge clk);
    bus.A   = a;
    bus.B   = b;
    bus.sub = s;
    exp_q.push_back(e);
  endtask

  // Sample one edge after the capture and compare with the queue head.
  task automatic capture_check(input string tag);
    logic [5:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, outs(), 6'bx);
    end else begin
      e = exp_q.pop_front();
      check(tag, outs(), e);
    end
  endtask

  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [5:0] e);
    drive(a, b, s, e);
    capture_check(tag);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rs;
    logic [5:0] held;
    n_vec   = 0;
    n_err   = 0;
    bus.A   = 4'd0;
    bus.B   = 4'd0;
    bus.sub = 1'b0;
    rst_n   = 1'b0;

    // Reset state with nonzero operands on the inputs
    bus.A = 4'd5;
    bus.B = 4'd6;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", outs(), 6'b0000_0_0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived expectations {sum,ovfl,cout}
    apply("add_3_4",      4'd3,   4'd4,   1'b0, 6'b0111_0_0);
    apply("sub_5_3",      4'd5,   4'd3,   1'b1, 6'b0010_0_1);
    apply("add_7_1",      4'd7,   4'd1,   1'b0, 6'b1000_1_0);
    apply("sub_m8_1",     4'b1000, 4'd1,  1'b1, 6'b0111_1_1);
    apply("sub_0_m8",     4'd0,   4'b1000, 1'b1, 6'b1000_1_0);
    apply("add_m8_m8",    4'b1000, 4'b1000, 1'b0, 6'b0000_1_1);
    apply("add_m3_m4",    4'b1101, 4'b1100, 1'b0, 6'b1001_0_1);
    apply("sub_m3_4",     4'b1101, 4'd4,   1'b1, 6'b1001_0_1);

    // Asynchronous reset between edges clears nonzero outputs without a clock
    apply("pre_reset",    4'd6,   4'd1,   1'b0, 6'b0111_0_0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 6'b0000_0_0);
    @(posedge clk);
    #1;
    check("reset_over_edge", outs(), 6'b0000_0_0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset",   4'd2,   4'd3,   1'b1, model(4'd2, 4'd3, 1'b1));

    // Latency stream: new operands every cycle; outputs must track the
    // previous edge and stay put while the next operands are presented.
    drive(4'd1, 4'd2, 1'b0, model(4'd1, 4'd2, 1'b0));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      held = exp_q.pop_front();
      check("latency_edge", outs(), held);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      drive(ra, rb, rs, model(ra, rb, rs));
      #1;
      check("latency_hold", outs(), held);
    end
    capture_check("latency_last");

    // Random vectors
    for (int i = 0; i < 150; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rs = 1'($urandom);
      apply("random", ra, rb, rs, model(ra, rb, rs));
    end

    // Exhaustive sweep of all {A,B,sub}
    for (int k = 0; k < 512; k++) begin
      ra = 4'(k >> 5);
      rb = 4'(k >> 1);
      rs = 1'(k);
      apply("sweep", ra, rb, rs, model(ra, rb, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
